control_unit: RTL and testbench

//  Hardwired Moore control sequencer that drives the datapath's control inputs.

---
 rtl/cpu_pkg.sv | 90 +++++++++
 rtl/reg_select_decoder.sv | 25 ++
 rtl/control_unit.sv | 186 ++++++++++++++++++
 tb/tb_control_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the hardwired control sequencer:
//   - register-file size and IR field positions
//   - opcode values and the matching ALU_select codes
//   - sequencer state encoding (RST, T0..T6, HALT)
//   - small decode helpers used by the next-state and output logic
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int NREG = 16;
    localparam int OPW  = 5;
    localparam int RW   = 4;

    // IR field bit positions: op | ra | rb | rc | (unused low bits)
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Opcodes
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b01001;
    localparam logic [OPW-1:0] OP_OR   = 5'b01010;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    // ALU operation codes driven on ALU_select
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_NEG  = 4'b1010;
    localparam logic [3:0] ALU_NOT  = 4'b1011;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    // Maps an opcode to its ALU operation; unknown opcodes give ALU_NONE
    function automatic logic [3:0] aluSel(input logic [OPW-1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_NONE;
        endcase
    endfunction

    // True for every opcode that runs through the execute steps (HALT excluded)
    function automatic logic isAluOp(input logic [OPW-1:0] op);
        return aluSel(op) != ALU_NONE;
    endfunction

    // Single-source ops take their only operand from rb
    function automatic logic isUnaryOp(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Ops whose result is 64 bits and needs the extra HI/LO step
    function automatic logic isWideOp(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// ---------------------------------------------------------------------------
// reg_select_decoder
// Turns a 4-bit register field into a one-hot register select.
// Ports:
//   i_field   in  4   register number (0..15, R0 included)
//   i_en      in  1   when low the output is all zero
//   o_onehot  out 16  bit n set when i_field == n and i_en == 1
// ---------------------------------------------------------------------------
module reg_select_decoder
    import cpu_pkg::*;
(
    input  logic [RW-1:0]   i_field,
    input  logic            i_en,
    output logic [NREG-1:0] o_onehot
);

    // Plain binary-to-one-hot decode gated by the enable
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_field] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired Moore sequencer stepping each instruction through T0..T6 and
// driving the datapath control inputs. Outputs are a pure decode of the state
// register and the IR contents.
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous active-high reset
//   ir             in  32   datapath IR (op/ra/rb/rc fields)
//   r_in, r_out    out 16   one-hot register load enables / bus drives
//   PCout..inPortout out 1  bus drivers (at most one active per state)
//   PC_in..LO_in   out  1   register load enables
//   Inc_PC         out  1   ALU forms PC+1
//   read           out  1   MDR loads from memory
//   ALU_select     out  4   ALU operation
//   run            out  1   high while sequencing
// ---------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     ir,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic            PCout,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            MDRout,
    output logic            HIout,
    output logic            LOout,
    output logic            Cout,
    output logic            inPortout,
    output logic            PC_in,
    output logic            IR_in,
    output logic            Y_in,
    output logic            Z_in,
    output logic            MAR_in,
    output logic            MDR_in,
    output logic            HI_in,
    output logic            LO_in,
    output logic            Inc_PC,
    output logic            read,
    output logic [3:0]      ALU_select,
    output logic            run
);

    state_t r_state;
    state_t w_nextState;

    logic [OPW-1:0] w_op;
    logic [RW-1:0]  w_ra;
    logic [RW-1:0]  w_rb;
    logic [RW-1:0]  w_rc;
    logic [14:0]    w_unused_irLow;

    logic           w_rinEn;
    logic           w_routEn;
    logic [RW-1:0]  w_routSel;

    assign w_op           = ir[OP_MSB:OP_LSB];
    assign w_ra           = ir[RA_MSB:RA_LSB];
    assign w_rb           = ir[RB_MSB:RB_LSB];
    assign w_rc           = ir[RC_MSB:RC_LSB];
    assign w_unused_irLow = ir[14:0];

    // State register; reset wins from any state and aborts the instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The opcode branch is taken in T3 because the new IR
    // value only becomes visible after the T2 edge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RST:  w_nextState = ST_T0;
            ST_T0:   w_nextState = ST_T1;
            ST_T1:   w_nextState = ST_T2;
            ST_T2:   w_nextState = ST_T3;
            ST_T3: begin
                if (w_op == OP_HALT) begin
                    w_nextState = ST_HALT;
                end else if (!isAluOp(w_op)) begin
                    w_nextState = ST_T0;
                end else begin
                    w_nextState = ST_T4;
                end
            end
            ST_T4:   w_nextState = ST_T5;
            ST_T5:   w_nextState = isWideOp(w_op) ? ST_T6 : ST_T0;
            ST_T6:   w_nextState = ST_T0;
            ST_HALT: w_nextState = ST_HALT;
            default: w_nextState = ST_RST;
        endcase
    end

    // Output decode. Everything defaults low so RST, HALT and the T3 of an
    // invalid/HALT opcode leave the datapath untouched.
    always_comb begin
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        MDRout     = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        Cout       = 1'b0;
        inPortout  = 1'b0;
        PC_in      = 1'b0;
        IR_in      = 1'b0;
        Y_in       = 1'b0;
        Z_in       = 1'b0;
        MAR_in     = 1'b0;
        MDR_in     = 1'b0;
        HI_in      = 1'b0;
        LO_in      = 1'b0;
        Inc_PC     = 1'b0;
        read       = 1'b0;
        ALU_select = ALU_NONE;
        w_rinEn    = 1'b0;
        w_routEn   = 1'b0;
        w_routSel  = w_rb;
        run        = (r_state != ST_RST) && (r_state != ST_HALT);
        case (r_state)
            ST_T0: begin
                PCout  = 1'b1;
                MAR_in = 1'b1;
                Inc_PC = 1'b1;
                Z_in   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PC_in   = 1'b1;
                read    = 1'b1;
                MDR_in  = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IR_in  = 1'b1;
            end
            ST_T3: begin
                if (isAluOp(w_op)) begin
                    w_routEn = 1'b1;
                    Y_in     = 1'b1;
                end
            end
            ST_T4: begin
                ALU_select = aluSel(w_op);
                Z_in       = 1'b1;
                w_routEn   = 1'b1;
                w_routSel  = isUnaryOp(w_op) ? w_rb : w_rc;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (isWideOp(w_op)) begin
                    LO_in = 1'b1;
                end else begin
                    w_rinEn = 1'b1;
                end
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HI_in    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    reg_select_decoder u_rinDecoder (
        .i_field  (w_ra),
        .i_en     (w_rinEn),
        .o_onehot (r_in)
    );

    reg_select_decoder u_routDecoder (
        .i_field  (w_routSel),
        .i_en     (w_routEn),
        .o_onehot (r_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit: walks several instructions through the
// sequencer and compares every step's outputs with hand-derived values.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, inPortout;
    logic        PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in;
    logic        Inc_PC, read, run;
    logic [3:0]  ALU_select;

    int total = 0;
    int bad   = 0;
    logic checkOn = 1'b0;

    // Flag masks, bit order matches the flags vector below
    localparam logic [17:0] F_READ   = 18'h1 << 0;
    localparam logic [17:0] F_INCPC  = 18'h1 << 1;
    localparam logic [17:0] F_LOIN   = 18'h1 << 2;
    localparam logic [17:0] F_HIIN   = 18'h1 << 3;
    localparam logic [17:0] F_MDRIN  = 18'h1 << 4;
    localparam logic [17:0] F_MARIN  = 18'h1 << 5;
    localparam logic [17:0] F_ZIN    = 18'h1 << 6;
    localparam logic [17:0] F_YIN    = 18'h1 << 7;
    localparam logic [17:0] F_IRIN   = 18'h1 << 8;
    localparam logic [17:0] F_PCIN   = 18'h1 << 9;
    localparam logic [17:0] F_MDROUT = 18'h1 << 14;
    localparam logic [17:0] F_ZHIOUT = 18'h1 << 15;
    localparam logic [17:0] F_ZLOOUT = 18'h1 << 16;
    localparam logic [17:0] F_PCOUT  = 18'h1 << 17;

    logic [17:0] flags;
    logic [54:0] obs;
    assign flags = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, inPortout,
                    PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, HI_in, LO_in, Inc_PC, read};
    assign obs   = {run, r_in, r_out, flags, ALU_select};

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .r_in       (r_in),
        .r_out      (r_out),
        .PCout      (PCout),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .MDRout     (MDRout),
        .HIout      (HIout),
        .LOout      (LOout),
        .Cout       (Cout),
        .inPortout  (inPortout),
        .PC_in      (PC_in),
        .IR_in      (IR_in),
        .Y_in       (Y_in),
        .Z_in       (Z_in),
        .MAR_in     (MAR_in),
        .MDR_in     (MDR_in),
        .HI_in      (HI_in),
        .LO_in      (LO_in),
        .Inc_PC     (Inc_PC),
        .read       (read),
        .ALU_select (ALU_select),
        .run        (run)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [54:0] mk(input logic rn, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [17:0] f,
                                       input logic [3:0] alu);
        return {rn, rin, rout, f, alu};
    endfunction

    function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    localparam logic [54:0] EXP_IDLE = 55'd0;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and compare the full output vector mid-cycle
    task automatic applyStimulus(input string tag, input logic [54:0] expected);
        @(negedge clk);
        checkOutput(tag, {9'd0, obs}, {9'd0, expected});
    endtask

    task automatic fetchSteps(input string tag);
        applyStimulus({tag, " T1"}, mk(1, 16'h0, 16'h0, F_ZLOOUT | F_PCIN | F_READ | F_MDRIN, 4'h0));
        applyStimulus({tag, " T2"}, mk(1, 16'h0, 16'h0, F_MDROUT | F_IRIN, 4'h0));
    endtask

    // Every cycle: at most one bus driver, register selects zero or one-hot
    always @(negedge clk) begin
        if (checkOn) begin
            logic busOk;
            busOk = ($countones({PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, inPortout})
                     + ((r_out != 16'h0) ? 1 : 0)) <= 1;
            checkOutput("one bus driver", {63'd0, busOk}, 64'd1);
            checkOutput("r_in onehot0", {63'd0, $onehot0(r_in)}, 64'd1);
            checkOutput("r_out onehot0", {63'd0, $onehot0(r_out)}, 64'd1);
        end
    end

    localparam logic [54:0] EXP_T0 = {1'b1, 16'h0, 16'h0, F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 4'h0};

    initial begin
        reset = 1'b1;
        ir    = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset state", {9'd0, obs}, {9'd0, EXP_IDLE});
        checkOn = 1'b1;

        // and R5,R2,R4
        ir    = 32'h4A920000;
        reset = 1'b0;
        applyStimulus("AND T0", EXP_T0);
        fetchSteps("AND");
        applyStimulus("AND T3", mk(1, 16'h0, 16'h0004, F_YIN, 4'h0));
        applyStimulus("AND T4", mk(1, 16'h0, 16'h0010, F_ZIN, 4'b0101));
        applyStimulus("AND T5", mk(1, 16'h0020, 16'h0, F_ZLOOUT, 4'h0));
        applyStimulus("AND back T0", EXP_T0);

        // mul R6,R3,R7
        ir = mkIr(5'b01110, 4'd6, 4'd3, 4'd7);
        fetchSteps("MUL");
        applyStimulus("MUL T3", mk(1, 16'h0, 16'h0008, F_YIN, 4'h0));
        applyStimulus("MUL T4", mk(1, 16'h0, 16'h0080, F_ZIN, 4'b1000));
        applyStimulus("MUL T5", mk(1, 16'h0, 16'h0, F_ZLOOUT | F_LOIN, 4'h0));
        applyStimulus("MUL T6", mk(1, 16'h0, 16'h0, F_ZHIOUT | F_HIIN, 4'h0));
        applyStimulus("MUL back T0", EXP_T0);

        // not R1,R9 (rc field nonzero, must be ignored)
        ir = mkIr(5'b10001, 4'd1, 4'd9, 4'd5);
        fetchSteps("NOT");
        applyStimulus("NOT T3", mk(1, 16'h0, 16'h0200, F_YIN, 4'h0));
        applyStimulus("NOT T4", mk(1, 16'h0, 16'h0200, F_ZIN, 4'b1011));
        applyStimulus("NOT T5", mk(1, 16'h0002, 16'h0, F_ZLOOUT, 4'h0));
        applyStimulus("NOT back T0", EXP_T0);

        // add R15,R0,R15 exercises both ends of the register fields
        ir = mkIr(5'b00011, 4'd15, 4'd0, 4'd15);
        fetchSteps("ADD");
        applyStimulus("ADD T3", mk(1, 16'h0, 16'h0001, F_YIN, 4'h0));
        applyStimulus("ADD T4", mk(1, 16'h0, 16'h8000, F_ZIN, 4'b0011));
        applyStimulus("ADD T5", mk(1, 16'h8000, 16'h0, F_ZLOOUT, 4'h0));
        applyStimulus("ADD back T0", EXP_T0);

        // undefined opcode behaves as a 4-cycle NOP
        ir = mkIr(5'b11111, 4'd3, 4'd4, 4'd5);
        fetchSteps("UNDEF");
        applyStimulus("UNDEF T3", mk(1, 16'h0, 16'h0, 18'h0, 4'h0));
        applyStimulus("UNDEF back T0", EXP_T0);

        // sub R2,R1,R6 interrupted by reset during T4
        ir = mkIr(5'b00100, 4'd2, 4'd1, 4'd6);
        fetchSteps("SUB");
        applyStimulus("SUB T3", mk(1, 16'h0, 16'h0002, F_YIN, 4'h0));
        applyStimulus("SUB T4", mk(1, 16'h0, 16'h0040, F_ZIN, 4'b0100));
        reset = 1'b1;
        applyStimulus("mid reset RST 1", EXP_IDLE);
        applyStimulus("mid reset RST 2", EXP_IDLE);
        reset = 1'b0;
        applyStimulus("after reset T0", EXP_T0);

        // HALT stops sequencing until reset
        ir = mkIr(5'b11011, 4'd0, 4'd0, 4'd0);
        fetchSteps("HALT");
        applyStimulus("HALT T3", mk(1, 16'h0, 16'h0, 18'h0, 4'h0));
        for (int i = 0; i < 20; i++) begin
            applyStimulus("HALT hold", EXP_IDLE);
        end
        reset = 1'b1;
        applyStimulus("halt reset RST", EXP_IDLE);
        reset = 1'b0;
        applyStimulus("restart T0", EXP_T0);

        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
